cam_cov_checker: RTL and testbench

Synthesizable golden-model checker and coverage collector for the CAM. It sits beside the DUT on the same request bus and mirrors every read and write into an internal LRU CAM model, predicting each read result. It records per-slot hit and evict coverage and same-key back-to-back covers, and flags read mismatches. It also scores the student testbench's error pulses against its own, counting false positives and false negatives within a ±RADIUS-cycle tolerance window.

---
 rtl/cam_chk_types.sv | 24 ++
 rtl/cam_lru_model.sv | 88 ++++++++
 rtl/cam_cov_checker.sv | 181 ++++++++++++++++++
 tb/tb_cam_cov_checker.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_chk_types.sv
// Shared types for the CAM golden-model checker: request and slot records
// plus the LRU rank width. The structs are sized by the CHK_* constants, so
// the checker's CAMSIZE/KEY_W/VAL_W parameters are expected to match them.
package cam_chk_types;

  localparam int CHK_CAMSIZE = 8;
  localparam int CHK_KEY_W   = 16;
  localparam int CHK_VAL_W   = 16;
  localparam int RANK_W      = $clog2(CHK_CAMSIZE);

  typedef struct packed {
    logic                 rw_n;
    logic [CHK_KEY_W-1:0] key;
    logic [CHK_VAL_W-1:0] val;
  } req_t;

  typedef struct packed {
    logic                 valid;
    logic [CHK_KEY_W-1:0] key;
    logic [CHK_VAL_W-1:0] val;
    logic [RANK_W-1:0]    rank;
  } slot_t;

endpackage

// File: rtl/cam_lru_model.sv
// LRU CAM reference model. Lookup is combinational on the current request;
// the slot array and ranks update on the clock. Rank 0 is LRU and
// CAMSIZE-1 is MRU; ranks always form a permutation over all slots.
module cam_lru_model
  import cam_chk_types::*;
#(
  parameter int CAMSIZE = CHK_CAMSIZE,
  parameter int VAL_W   = CHK_VAL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  req_t              req,
  output logic              hit,
  output logic [RANK_W-1:0] idx,
  output logic              evict,
  output logic [VAL_W-1:0]  exp_val
);

  localparam logic [RANK_W-1:0] MRU_RANK = RANK_W'(CAMSIZE - 1);

  slot_t slot_reg [CAMSIZE];

  logic [CAMSIZE-1:0] match;
  logic [CAMSIZE-1:0] free;
  logic [RANK_W-1:0]  hit_idx;
  logic [RANK_W-1:0]  free_idx;
  logic [RANK_W-1:0]  lru_idx;
  logic [RANK_W-1:0]  sel_idx;
  logic [RANK_W-1:0]  sel_rank;
  logic               any_free;
  logic               is_write;
  logic               touch;

  for (genvar gi = 0; gi < CAMSIZE; gi++) begin : g_slot_flags
    assign match[gi] = slot_reg[gi].valid && (slot_reg[gi].key == req.key);
    assign free[gi]  = !slot_reg[gi].valid;
  end

  // Lowest-index match, lowest-index free slot, and the slot holding rank 0
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    lru_idx  = '0;
    for (int i = CAMSIZE - 1; i >= 0; i--) begin
      if (match[i])                 hit_idx  = RANK_W'(i);
      if (free[i])                  free_idx = RANK_W'(i);
      if (slot_reg[i].rank == '0)   lru_idx  = RANK_W'(i);
    end
  end

  assign hit      = |match;
  assign any_free = |free;
  assign is_write = !req.rw_n;
  // A read miss leaves the model untouched; everything else refreshes a slot
  assign touch    = req_valid && (hit || is_write);
  assign sel_idx  = hit ? hit_idx : (any_free ? free_idx : lru_idx);
  assign sel_rank = slot_reg[sel_idx].rank;
  assign idx      = sel_idx;
  assign evict    = req_valid && is_write && !hit && !any_free;
  assign exp_val  = slot_reg[hit_idx].val;

  // Slot fill/update and LRU promotion of the selected slot
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CAMSIZE; i++) begin
        slot_reg[i].valid <= 1'b0;
        slot_reg[i].key   <= '0;
        slot_reg[i].val   <= '0;
        slot_reg[i].rank  <= RANK_W'(i);
      end
    end else if (touch) begin
      for (int i = 0; i < CAMSIZE; i++) begin
        if (RANK_W'(i) == sel_idx) begin
          slot_reg[i].rank <= MRU_RANK;
          if (is_write) begin
            slot_reg[i].valid <= 1'b1;
            slot_reg[i].key   <= req.key;
            slot_reg[i].val   <= req.val;
          end
        end else if (slot_reg[i].rank > sel_rank) begin
          slot_reg[i].rank <= slot_reg[i].rank - RANK_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cam_cov_checker.sv
// Golden-model checker and coverage collector for the CAM. Mirrors the
// request bus into cam_lru_model, checks DUT read data one cycle after each
// read hit, collects coverage, and scores student error pulses against the
// golden ones within a +/-RADIUS window.
// Build option: define CAM_CHK_SATURATE_EN to make false_pos/false_neg
// saturate instead of wrapping.
module cam_cov_checker
  import cam_chk_types::*;
#(
  parameter int CAMSIZE = CHK_CAMSIZE,
  parameter int KEY_W   = CHK_KEY_W,
  parameter int VAL_W   = CHK_VAL_W,
  parameter int RADIUS  = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mon_valid,
  input  logic               mon_rw_n,
  input  logic [KEY_W-1:0]   mon_key,
  input  logic [VAL_W-1:0]   mon_val_i,
  input  logic [VAL_W-1:0]   mon_val_o,
  input  logic               stu_error,
  output logic [CAMSIZE-1:0] hit_cov,
  output logic [CAMSIZE-1:0] evict_cov,
  output logic               ww_cov,
  output logic               wr_cov,
  output logic               grd_error,
  output logic [CNT_W-1:0]   false_pos,
  output logic [CNT_W-1:0]   false_neg
);

  localparam int HW = 2 * RADIUS + 1;

  req_t               cur_req;
  logic               m_hit;
  logic [RANK_W-1:0]  m_idx;
  logic               m_evict;
  logic [VAL_W-1:0]   m_exp;
  logic               rd_req;
  logic               wr_req;
  logic               fwd;
  logic [CAMSIZE-1:0] hit_set;
  logic [CAMSIZE-1:0] evict_set;
  logic               fp_inc;
  logic               fn_inc;

  logic               prev_wr_reg;
  logic [KEY_W-1:0]   prev_key_reg;
  logic [VAL_W-1:0]   prev_val_reg;
  logic               chk_pending_reg;
  logic [VAL_W-1:0]   chk_exp_reg;
  logic               grd_error_reg;
  logic [CAMSIZE-1:0] hit_cov_reg;
  logic [CAMSIZE-1:0] evict_cov_reg;
  logic               ww_cov_reg;
  logic               wr_cov_reg;
  logic [HW-1:0]      grd_hist_reg;
  logic [HW-1:0]      stu_hist_reg;
  logic [CNT_W-1:0]   fp_reg;
  logic [CNT_W-1:0]   fn_reg;

  assign cur_req = '{rw_n: mon_rw_n, key: mon_key, val: mon_val_i};
  assign rd_req  = mon_valid && mon_rw_n;
  assign wr_req  = mon_valid && !mon_rw_n;
  // The model already holds last cycle's write; the explicit bypass keeps
  // the expected value independent of model update ordering.
  assign fwd     = rd_req && prev_wr_reg && (prev_key_reg == mon_key);

  cam_lru_model #(
    .CAMSIZE (CAMSIZE),
    .VAL_W   (VAL_W)
  ) u_model (
    .clk       (clk),
    .rst       (rst),
    .req_valid (mon_valid),
    .req       (cur_req),
    .hit       (m_hit),
    .idx       (m_idx),
    .evict     (m_evict),
    .exp_val   (m_exp)
  );

  for (genvar gi = 0; gi < CAMSIZE; gi++) begin : g_cov_sets
    assign hit_set[gi]   = rd_req && m_hit && (m_idx == RANK_W'(gi));
    assign evict_set[gi] = m_evict && (m_idx == RANK_W'(gi));
  end

  // Remember the previous cycle's write for forwarding and ww/wr covers
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_wr_reg  <= 1'b0;
      prev_key_reg <= '0;
      prev_val_reg <= '0;
    end else begin
      prev_wr_reg  <= wr_req;
      prev_key_reg <= mon_key;
      prev_val_reg <= mon_val_i;
    end
  end

  // Sticky coverage bits
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cov_reg   <= '0;
      evict_cov_reg <= '0;
      ww_cov_reg    <= 1'b0;
      wr_cov_reg    <= 1'b0;
    end else begin
      hit_cov_reg   <= hit_cov_reg | hit_set;
      evict_cov_reg <= evict_cov_reg | evict_set;
      if (wr_req && prev_wr_reg && (prev_key_reg == mon_key)) ww_cov_reg <= 1'b1;
      if (rd_req && prev_wr_reg && (prev_key_reg == mon_key)) wr_cov_reg <= 1'b1;
    end
  end

  // Latch the expected value on a read hit and compare DUT data one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_pending_reg <= 1'b0;
      chk_exp_reg     <= '0;
      grd_error_reg   <= 1'b0;
    end else begin
      chk_pending_reg <= rd_req && m_hit;
      chk_exp_reg     <= fwd ? prev_val_reg : m_exp;
      grd_error_reg   <= chk_pending_reg && (mon_val_o != chk_exp_reg);
    end
  end

  // Error-pulse histories; index 0 is the newest sample, RADIUS is the centre
  if (HW > 1) begin : g_hist_shift
    always_ff @(posedge clk) begin
      if (rst) begin
        grd_hist_reg <= '0;
        stu_hist_reg <= '0;
      end else begin
        grd_hist_reg <= {grd_hist_reg[HW-2:0], grd_error_reg};
        stu_hist_reg <= {stu_hist_reg[HW-2:0], stu_error};
      end
    end
  end else begin : g_hist_single
    always_ff @(posedge clk) begin
      if (rst) begin
        grd_hist_reg <= '0;
        stu_hist_reg <= '0;
      end else begin
        grd_hist_reg <= grd_error_reg;
        stu_hist_reg <= stu_error;
      end
    end
  end

  // A centred pulse with no partner anywhere in the other window is unmatched
  assign fn_inc = grd_hist_reg[RADIUS] && (stu_hist_reg == '0);
  assign fp_inc = stu_hist_reg[RADIUS] && (grd_hist_reg == '0);

  // False-positive / false-negative counters
  always_ff @(posedge clk) begin
    if (rst) begin
      fp_reg <= '0;
      fn_reg <= '0;
    end else begin
`ifdef CAM_CHK_SATURATE_EN
      if (fp_inc && !(&fp_reg)) fp_reg <= fp_reg + CNT_W'(1);
      if (fn_inc && !(&fn_reg)) fn_reg <= fn_reg + CNT_W'(1);
`else
      if (fp_inc) fp_reg <= fp_reg + CNT_W'(1);
      if (fn_inc) fn_reg <= fn_reg + CNT_W'(1);
`endif
    end
  end

  assign hit_cov   = hit_cov_reg;
  assign evict_cov = evict_cov_reg;
  assign ww_cov    = ww_cov_reg;
  assign wr_cov    = wr_cov_reg;
  assign grd_error = grd_error_reg;
  assign false_pos = fp_reg;
  assign false_neg = fn_reg;

endmodule

// File: tb/tb_cam_cov_checker.sv
// Scoreboard bench for cam_cov_checker: stimulus pushes the expected
// grd_error value for each checked read; a negedge monitor pops and compares.
module tb_cam_cov_checker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mon_valid;
  logic        mon_rw_n;
  logic [15:0] mon_key;
  logic [15:0] mon_val_i;
  logic [15:0] mon_val_o;
  logic        stu_error;
  logic [7:0]  hit_cov;
  logic [7:0]  evict_cov;
  logic        ww_cov;
  logic        wr_cov;
  logic        grd_error;
  logic [15:0] false_pos;
  logic [15:0] false_neg;

  // Second instance with a 2-bit counter, fed only student pulses
  logic        s_valid = 1'b0;
  logic        s_rw_n = 1'b1;
  logic [15:0] s_key = 16'h0;
  logic [15:0] s_val_i = 16'h0;
  logic [15:0] s_val_o = 16'h0;
  logic        s_stu_error;
  logic [7:0]  s_hit_cov;
  logic [7:0]  s_evict_cov;
  logic        s_ww_cov;
  logic        s_wr_cov;
  logic        s_grd_error;
  logic [1:0]  s_false_pos;
  logic [1:0]  s_false_neg;

  cam_cov_checker u_dut (
    .clk (clk), .rst (rst), .mon_valid (mon_valid), .mon_rw_n (mon_rw_n),
    .mon_key (mon_key), .mon_val_i (mon_val_i), .mon_val_o (mon_val_o),
    .stu_error (stu_error), .hit_cov (hit_cov), .evict_cov (evict_cov),
    .ww_cov (ww_cov), .wr_cov (wr_cov), .grd_error (grd_error),
    .false_pos (false_pos), .false_neg (false_neg)
  );

  cam_cov_checker #(.CNT_W(2)) u_sat (
    .clk (clk), .rst (rst), .mon_valid (s_valid), .mon_rw_n (s_rw_n),
    .mon_key (s_key), .mon_val_i (s_val_i), .mon_val_o (s_val_o),
    .stu_error (s_stu_error), .hit_cov (s_hit_cov), .evict_cov (s_evict_cov),
    .ww_cov (s_ww_cov), .wr_cov (s_wr_cov), .grd_error (s_grd_error),
    .false_pos (s_false_pos), .false_neg (s_false_neg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   at;
    logic grd;
  } exp_t;

  exp_t        exp_q[$];
  int          stu_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] carry_val = 16'h0;

`ifdef CAM_CHK_SATURATE_EN
  localparam logic [1:0] SAT_EXP = 2'd3;
`else
  localparam logic [1:0] SAT_EXP = 2'd1;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s = %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // One bus cycle; mon_val_o carries the response chosen for the previous read.
  // chk_code: -1 no check expected, 0 expect match, 1 expect mismatch.
  task automatic issue(input logic v, input logic rw, input logic [15:0] k,
                       input logic [15:0] vi, input logic [15:0] ret, input int chk_code);
    exp_t e;
    mon_val_o = carry_val;
    mon_valid = v;
    mon_rw_n  = rw;
    mon_key   = k;
    mon_val_i = vi;
    carry_val = ret;
    if (chk_code >= 0) begin
      e.at  = cyc + 2;
      e.grd = (chk_code == 1);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] k, input logic [15:0] v);
    issue(1'b1, 1'b0, k, v, 16'h0, -1);
  endtask

  task automatic rd(input logic [15:0] k, input logic [15:0] ret, input int chk_code);
    issue(1'b1, 1'b1, k, 16'h0, ret, chk_code);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 1'b1, 16'h0, 16'h0, 16'h0, -1);
  endtask

  // Student pulse driver from the schedule
  initial begin
    stu_error = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      stu_error = 1'b0;
      foreach (stu_q[i]) if (stu_q[i] == cyc) stu_error = 1'b1;
    end
  end

  // Monitor: compares grd_error against the scoreboard every cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (grd_error !== e.grd) begin
          errors++;
          $display("FAIL grd_error: got %0b expected %0b (cycle %0d)", grd_error, e.grd, cyc);
        end else begin
          $display("ok   grd_error = %0b (cycle %0d)", grd_error, cyc);
        end
      end else if (grd_error !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL grd_spurious: got %0b expected 0 (cycle %0d)", grd_error, cyc);
      end
    end
  end

  initial begin
    int c;
    rst = 1'b1; mon_valid = 1'b0; mon_rw_n = 1'b1; mon_key = '0;
    mon_val_i = '0; mon_val_o = '0; s_stu_error = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset state
    chk("rst_hit_cov", 32'(hit_cov), 32'h0);
    chk("rst_evict_cov", 32'(evict_cov), 32'h0);
    chk("rst_ww_wr", {30'h0, ww_cov, wr_cov}, 32'h0);
    chk("rst_counters", {false_pos, false_neg}, 32'h0);
    chk("rst_sat_fp", 32'(s_false_pos), 32'h0);

    // Fill all slots, then read each back correctly
    for (int k = 0; k < 8; k++) wr(16'(k), 16'(k + 'h100));
    for (int k = 0; k < 8; k++) rd(16'(k), 16'(k + 'h100), 0);
    chk("s1_hit_cov", 32'(hit_cov), 32'hFF);
    chk("s1_evict_cov", 32'(evict_cov), 32'h0);
    chk("s1_ww_cov", 32'(ww_cov), 32'h0);
    chk("s1_wr_cov", 32'(wr_cov), 32'h0);

    // Full CAM: key 0 is LRU after touching key 3, so key 8 evicts slot 0
    rd(16'd3, 16'h103, 0);
    wr(16'd8, 16'h108);
    chk("s2_evict_cov", 32'(evict_cov), 32'h01);
    rd(16'd0, 16'hDEAD, -1);
    idle(3);
    chk("s2_hit_cov", 32'(hit_cov), 32'hFF);

    // Same-key write/write/read, forwarded value mismatch, then a good read
    wr(16'd5, 16'hAAAA);
    wr(16'd5, 16'hCCCC);
    rd(16'd5, 16'hBBBB, 1);
    rd(16'd5, 16'hCCCC, 0);
    chk("s3_ww_cov", 32'(ww_cov), 32'h1);
    chk("s3_wr_cov", 32'(wr_cov), 32'h1);
    idle(6);
    chk("s3_counts", {false_pos, false_neg}, {16'd0, 16'd1});

    // Student pulse one cycle after the golden pulse: matched both ways
    c = cyc; stu_q.push_back(c + 3);
    rd(16'd5, 16'hBBBB, 1);
    idle(6);
    chk("s4a_counts", {false_pos, false_neg}, {16'd0, 16'd1});

    // Three cycles late: unmatched both ways
    c = cyc; stu_q.push_back(c + 5);
    rd(16'd5, 16'hBBBB, 1);
    idle(8);
    chk("s4b_counts", {false_pos, false_neg}, {16'd1, 16'd2});

    // Two cycles late: just outside the window
    c = cyc; stu_q.push_back(c + 4);
    rd(16'd5, 16'hBBBB, 1);
    idle(8);
    chk("s4c_counts", {false_pos, false_neg}, {16'd2, 16'd3});

    // Same cycle: matched
    c = cyc; stu_q.push_back(c + 2);
    rd(16'd5, 16'hBBBB, 1);
    idle(6);
    chk("s4d_counts", {false_pos, false_neg}, {16'd2, 16'd3});

    // Reset right after a bad read: the pending check is dropped
    rd(16'd5, 16'hBBBB, -1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("s5_hit_cov", 32'(hit_cov), 32'h0);
    chk("s5_evict_cov", 32'(evict_cov), 32'h0);
    chk("s5_ww_wr", {30'h0, ww_cov, wr_cov}, 32'h0);
    chk("s5_grd", 32'(grd_error), 32'h0);
    chk("s5_counters", {false_pos, false_neg}, 32'h0);
    rd(16'd5, 16'hBBBB, -1);
    idle(4);
    chk("s5_miss_hit_cov", 32'(hit_cov), 32'h0);

    // Five isolated student pulses into a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      s_stu_error = 1'b1;
      idle(1);
      s_stu_error = 1'b0;
      idle(3);
    end
    idle(4);
    chk("s6_sat_fp", 32'(s_false_pos), 32'(SAT_EXP));
    chk("s6_sat_fn", 32'(s_false_neg), 32'h0);

    idle(2);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
